// File: rtl/imul_int_mul_var_param.sv
// Variable-latency shift-and-add unsigned multiplier, val/rdy streams, one transaction in flight.
// Optional build macro IMUL_VAR_ZERO_SKIP_EN: skip up to four trailing zeros of b per CALC cycle.

module imul_int_mul_var_param #(
  parameter int unsigned NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS-1:0] istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] ostream_msg
);

  localparam int unsigned PW = 2 * NBITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     a_q, a_d;
  logic [PW-1:0]     res_q, res_d;
  logic [NBITS-1:0]  b_q, b_d;
  logic              istream_rdy_q;
  logic              ostream_val_q;
  logic [2:0]        shamt_s;

`ifdef IMUL_VAR_ZERO_SKIP_EN
  logic [3:0] b_nib_s;

  // Trailing-zero count of the low nibble, saturating at four.
  function automatic logic [2:0] skip_amt(input logic [3:0] nib);
    logic [2:0] s;
    if (nib[0]) begin
      s = 3'd1;
    end else if (nib[1]) begin
      s = 3'd1;
    end else if (nib[2]) begin
      s = 3'd2;
    end else if (nib[3]) begin
      s = 3'd3;
    end else begin
      s = 3'd4;
    end
    return s;
  endfunction

  // Narrow operands are zero-padded so the encoder always sees four bits.
  if (NBITS >= 4) begin : g_nib_wide
    assign b_nib_s = b_q[3:0];
  end else begin : g_nib_narrow
    assign b_nib_s = {{(4-NBITS){1'b0}}, b_q};
  end

  assign shamt_s = skip_amt(b_nib_s);
`else
  assign shamt_s = 3'd1;
`endif

  // Next-state and datapath update for the three-phase iteration.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (istream_val) begin
          a_d     = {{NBITS{1'b0}}, istream_msg[PW-1:NBITS]};
          b_d     = istream_msg[NBITS-1:0];
          res_d   = {PW{1'b0}};
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (b_q == {NBITS{1'b0}}) begin
          state_d = ST_DONE;
        end else if (b_q[0]) begin
          res_d = res_q + a_q;
          a_d   = a_q << 1'b1;
          b_d   = b_q >> 1'b1;
        end else begin
          a_d   = a_q << shamt_s;
          b_d   = b_q >> shamt_s;
        end
      end
      ST_DONE: begin
        if (ostream_rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and handshake flags; flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      a_q           <= {PW{1'b0}};
      b_q           <= {NBITS{1'b0}};
      res_q         <= {PW{1'b0}};
      istream_rdy_q <= 1'b1;
      ostream_val_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      istream_rdy_q <= (state_d == ST_IDLE);
      ostream_val_q <= (state_d == ST_DONE);
    end
  end

  assign istream_rdy = istream_rdy_q;
  assign ostream_val = ostream_val_q;
  assign ostream_msg = ostream_val_q ? res_q : {PW{1'b0}};

  imul_int_mul_var_param_chk #(
    .PW (PW)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .istream_rdy (istream_rdy),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

endmodule

// Output-stream protocol properties for the multiplier.
module imul_int_mul_var_param_chk #(
  parameter int unsigned PW = 64
) (
  input logic          clk,
  input logic          reset,
  input logic          istream_rdy,
  input logic          ostream_val,
  input logic          ostream_rdy,
  input logic [PW-1:0] ostream_msg
);

  a_no_overlap: assert property (@(posedge clk) disable iff (!reset)
    !(istream_rdy && ostream_val));

  a_msg_zero: assert property (@(posedge clk) disable iff (!reset)
    !ostream_val |-> (ostream_msg == {PW{1'b0}}));

  a_hold: assert property (@(posedge clk) disable iff (!reset)
    (ostream_val && !ostream_rdy) |=> (ostream_val && $stable(ostream_msg)));

endmodule

// File: tb/tb_imul_int_mul_var_param.sv
// Directed bench for the variable-latency multiplier: 32-bit vectors plus an 8-bit random stream.
module tb_imul_int_mul_var_param;

  logic        clk;
  logic        reset;

  logic        ival32, irdy32, oval32, ordy32;
  logic [63:0] imsg32, omsg32;
  logic        ival8, irdy8, oval8, ordy8;
  logic [15:0] imsg8, omsg8;

  int tests_run;
  int tests_failed;

  imul_int_mul_var_param #(.NBITS(32)) dut32 (
    .clk(clk), .reset(reset),
    .istream_val(ival32), .istream_rdy(irdy32), .istream_msg(imsg32),
    .ostream_val(oval32), .ostream_rdy(ordy32), .ostream_msg(omsg32)
  );

  imul_int_mul_var_param #(.NBITS(8)) dut8 (
    .clk(clk), .reset(reset),
    .istream_val(ival8), .istream_rdy(irdy8), .istream_msg(imsg8),
    .ostream_val(oval8), .ostream_rdy(ordy8), .ostream_msg(omsg8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference latency for an 8-bit b, written from the shift-step definition.
  function automatic int ref_lat8(input logic [7:0] b);
    int steps;
    logic [7:0] bb;
    steps = 0;
    bb = b;
`ifdef IMUL_VAR_ZERO_SKIP_EN
    while (bb != 8'd0) begin
      if (bb[0])            bb = bb >> 1;
      else if (bb[1])       bb = bb >> 1;
      else if (bb[2])       bb = bb >> 2;
      else if (bb[3])       bb = bb >> 3;
      else                  bb = bb >> 4;
      steps++;
    end
`else
    for (int i = 0; i < 8; i++) if (b[i]) steps = i + 1;
`endif
    return 2 + steps;
  endfunction

  task automatic txn32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_p, input int exp_lat, input int stall);
    int   lat;
    logic zero_bad;
    chk_eq($sformatf("%s_irdy", tag), 64'(irdy32), 64'd1);
    ordy32 = (stall == 0);
    ival32 = 1'b1;
    imsg32 = {a, b};
    @(posedge clk);
    @(negedge clk);
    ival32   = 1'b0;
    lat      = 1;
    zero_bad = 1'b0;
    while (!oval32 && lat < 100) begin
      if (omsg32 !== 64'd0) zero_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk_eq($sformatf("%s_lat", tag), 64'(lat), 64'(exp_lat));
    chk_eq($sformatf("%s_msg", tag), omsg32, exp_p);
    chk_eq($sformatf("%s_msg0", tag), 64'(zero_bad), 64'd0);
    for (int k = 0; k < stall; k++) begin
      chk_eq($sformatf("%s_hold_val", tag), 64'(oval32), 64'd1);
      chk_eq($sformatf("%s_hold_msg", tag), omsg32, exp_p);
      chk_eq($sformatf("%s_hold_irdy", tag), 64'(irdy32), 64'd0);
      @(negedge clk);
    end
    ordy32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_eq($sformatf("%s_post_val", tag), 64'(oval32), 64'd0);
    chk_eq($sformatf("%s_post_irdy", tag), 64'(irdy32), 64'd1);
  endtask

  initial begin
    int   lat;
    int   guard;
    logic flag;
    logic [7:0] a8, b8;
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b0;
    ival32 = 1'b0; ordy32 = 1'b1; imsg32 = 64'd0;
    ival8  = 1'b0; ordy8  = 1'b1; imsg8  = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    chk_eq("rst_irdy", 64'(irdy32), 64'd1);
    chk_eq("rst_oval", 64'(oval32), 64'd0);
    chk_eq("rst_omsg", omsg32, 64'd0);
    chk_eq("rst8_irdy", 64'(irdy8), 64'd1);

`ifdef IMUL_VAR_ZERO_SKIP_EN
    txn32("m3x4",    32'd3,          32'd4,          64'h0000_0000_0000_000C, 4,  0);
    txn32("big_sp",  32'h0000_0010,  32'h0000_0100,  64'h0000_0000_0000_1000, 5,  0);
    txn32("ff_msb",  32'hFFFF_FFFF,  32'h8000_0000,  64'h7FFF_FFFF_8000_0000, 11, 0);
`else
    txn32("m3x4",    32'd3,          32'd4,          64'h0000_0000_0000_000C, 5,  0);
    txn32("big_sp",  32'h0000_0010,  32'h0000_0100,  64'h0000_0000_0000_1000, 11, 0);
    txn32("ff_msb",  32'hFFFF_FFFF,  32'h8000_0000,  64'h7FFF_FFFF_8000_0000, 34, 0);
`endif
    txn32("ffxff",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 34, 0);
    txn32("bzero",   32'h0000_1234,  32'd0,          64'd0,                   2,  0);
    txn32("bone",    32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF, 3,  0);

    // Abort a long multiply with a one-cycle reset pulse.
    ival32 = 1'b1;
    imsg32 = {32'd5, 32'h8000_0000};
    @(posedge clk);
    @(negedge clk);
    ival32 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk_eq("abort_irdy", 64'(irdy32), 64'd1);
    chk_eq("abort_oval", 64'(oval32), 64'd0);
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (oval32 || omsg32 !== 64'd0) flag = 1'b1;
      @(negedge clk);
    end
    chk_eq("abort_no_stale", 64'(flag), 64'd0);

    txn32("stall42", 32'd7, 32'd6, 64'd42, 5, 5);

    // 8-bit stream: back-to-back random pairs with random sink stalls.
    for (int n = 0; n < 200; n++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      guard = 0;
      while (!irdy8 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk_eq("r8_rdy_timeout", 64'd0, 64'd1);
      ival8 = 1'b1;
      imsg8 = {a8, b8};
      @(posedge clk);
      @(negedge clk);
      ival8 = 1'b0;
      lat = 1;
      while (!oval8 && lat < 100) begin
        ordy8 = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      chk_eq($sformatf("r8_lat_%0d", n), 64'(lat), 64'(ref_lat8(b8)));
      chk_eq($sformatf("r8_msg_%0d", n), 64'(omsg8), 64'(16'(a8) * 16'(b8)));
      flag  = 1'b0;
      guard = 0;
      ordy8 = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      while (!ordy8 && guard < 20) begin
        @(negedge clk);
        if (!oval8 || omsg8 !== 16'(a8) * 16'(b8)) flag = 1'b1;
        ordy8 = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
        guard++;
      end
      ordy8 = 1'b1;
      chk_eq($sformatf("r8_hold_%0d", n), 64'(flag), 64'd0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
